// File: rtl/writeback_vec.sv
// writeback_vec: writeback stage of the vector filter CPU.
// Drives the register-file write port (RegWriteW, wa3w, wd3).
//   - ALU results are forwarded with one cycle of latency.
//   - Vector loads arrive one lane per rvalid cycle. They are assembled
//     in a per-lane buffer and committed as a single full-vector write.
//     stallM holds the memory stage while assembly is in progress.
// Ports:
//   clk, RST        clock, asynchronous active-low reset
//   validM, RegWriteM, MemtoRegM, wa3m, ALUResultM  memory-stage instruction
//   rdata, rvalid   lane-serial load data from data memory
//   stallM          memory stage must hold its inputs
//   RegWriteW, wa3w, wd3  register-file write port

// Per-lane slice. It holds one assembly-buffer lane and one wd3 lane.
module writeback_vec_lane #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_en,    // store this load lane
    input  logic [WIDTH-1:0] cap_data,
    input  logic             alu_en,    // ALU forward into wd
    input  logic [WIDTH-1:0] alu_data,
    input  logic             ld_en,     // load commit into wd
    output logic [WIDTH-1:0] wd
);
    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] ld_val;

    // The last lane is captured in the same cycle as the commit.
    // That lane bypasses its own buffer.
    assign ld_val = cap_en ? cap_data : asm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q <= '0;
            wd    <= '0;
        end else begin
            if (cap_en) asm_q <= cap_data;
            if (alu_en)     wd <= alu_data;
            else if (ld_en) wd <= ld_val;
        end
    end
endmodule

module writeback_vec #(
    parameter int WIDTH = 18,
    parameter int LANES = 3,
    parameter int AW    = 4
) (
    input  logic                        clk,
    input  logic                        RST,
    input  logic                        validM,
    input  logic                        RegWriteM,
    input  logic                        MemtoRegM,
    input  logic [AW-1:0]               wa3m,
    input  logic [LANES-1:0][WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0]            rdata,
    input  logic                        rvalid,
    output logic                        stallM,
    output logic                        RegWriteW,
    output logic [AW-1:0]               wa3w,
    output logic [LANES-1:0][WIDTH-1:0] wd3
);
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   pend_wa;
    logic            pend_we;

    logic            acc_alu, acc_ld, commit, ld_wr;
    logic [LANES-1:0] cap;

    assign acc_alu = (state == IDLE) && validM && !MemtoRegM;
    assign acc_ld  = (state == IDLE) && validM &&  MemtoRegM;
    assign commit  = (state == LOAD) && rvalid && (cnt == LAST);
    // A load whose pending RegWrite is 0 leaves wd3 and wa3w untouched.
    assign ld_wr   = commit && pend_we;
    assign stallM  = (state == LOAD);

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_wa   <= '0;
            pend_we   <= 1'b0;
            RegWriteW <= 1'b0;
            wa3w      <= '0;
        end else begin
            RegWriteW <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc_alu) begin
                        wa3w      <= wa3m;
                        RegWriteW <= RegWriteM;
                    end else if (acc_ld) begin
                        pend_wa <= wa3m;
                        pend_we <= RegWriteM;
                        cnt     <= '0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (rvalid) begin
                        if (commit) begin
                            cnt       <= '0;
                            state     <= IDLE;
                            RegWriteW <= pend_we;
                            if (pend_we) wa3w <= pend_wa;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign cap[i] = (state == LOAD) && rvalid && (cnt == CW'(i));

        writeback_vec_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .rst_n    (RST),
            .cap_en   (cap[i]),
            .cap_data (rdata),
            .alu_en   (acc_alu),
            .alu_data (ALUResultM[i]),
            .ld_en    (ld_wr),
            .wd       (wd3[i])
        );
    end
endmodule

// File: tb/tb_writeback_vec.sv
module tb_writeback_vec;
    localparam int WIDTH = 18, LANES = 3, AW = 4;

    logic                        clk, RST;
    logic                        validM, RegWriteM, MemtoRegM, rvalid;
    logic [AW-1:0]               wa3m;
    logic [LANES-1:0][WIDTH-1:0] ALUResultM;
    logic [WIDTH-1:0]            rdata;
    logic                        stallM, RegWriteW;
    logic [AW-1:0]               wa3w;
    logic [LANES-1:0][WIDTH-1:0] wd3;

    int n_chk = 0, n_pass = 0;

    writeback_vec #(.WIDTH(WIDTH), .LANES(LANES), .AW(AW)) dut (
        .clk(clk), .RST(RST), .validM(validM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .wa3m(wa3m), .ALUResultM(ALUResultM),
        .rdata(rdata), .rvalid(rvalid), .stallM(stallM),
        .RegWriteW(RegWriteW), .wa3w(wa3w), .wd3(wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h exp %h", tag, obs, exp);
    endtask

    // Advance one cycle. Drive and check at #1 after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [AW-1:0] a, input logic we,
                       input logic [WIDTH-1:0] l2, l1, l0);
        validM = 1; MemtoRegM = 0; RegWriteM = we; wa3m = a;
        ALUResultM = {l2, l1, l0};
    endtask

    task automatic ld(input logic [AW-1:0] a, input logic we);
        validM = 1; MemtoRegM = 1; RegWriteM = we; wa3m = a;
    endtask

    function automatic logic [63:0] v3(input logic [WIDTH-1:0] l2, l1, l0);
        return 64'({l2, l1, l0});
    endfunction

    initial begin
        RST = 0; validM = 0; RegWriteM = 0; MemtoRegM = 0; wa3m = '0;
        ALUResultM = '0; rdata = '0; rvalid = 0;
        #12;
        chk("rst_we",    64'(RegWriteW), 64'd0);
        chk("rst_stall", 64'(stallM),    64'd0);
        chk("rst_wa",    64'(wa3w),      64'd0);
        chk("rst_wd",    64'(wd3),       64'd0);
        tick(); RST = 1;

        // ALU write, latency 1, single-cycle pulse
        alu(4'd5, 1, 18'h3FFFF, 18'h00001, 18'h12345);
        tick(); validM = 0;
        chk("alu_we", 64'(RegWriteW), 64'd1);
        chk("alu_wa", 64'(wa3w), 64'd5);
        chk("alu_wd", 64'(wd3), v3(18'h3FFFF, 18'h00001, 18'h12345));
        tick();
        chk("alu_we_drop", 64'(RegWriteW), 64'd0);

        // Load with three consecutive lanes
        ld(4'd9, 1);
        tick(); validM = 0;
        chk("ld_stall0", 64'(stallM), 64'd1);
        chk("ld_we0", 64'(RegWriteW), 64'd0);
        rvalid = 1; rdata = 18'h00011; tick();
        chk("ld_stall1", 64'(stallM), 64'd1);
        chk("ld_wd_hold1", 64'(wd3), v3(18'h3FFFF, 18'h00001, 18'h12345));
        rdata = 18'h00022; tick();
        chk("ld_stall2", 64'(stallM), 64'd1);
        chk("ld_wd_hold2", 64'(wd3), v3(18'h3FFFF, 18'h00001, 18'h12345));
        rdata = 18'h00033; tick(); rvalid = 0;
        chk("ld_stall_fall", 64'(stallM), 64'd0);
        chk("ld_we", 64'(RegWriteW), 64'd1);
        chk("ld_wa", 64'(wa3w), 64'd9);
        chk("ld_wd", 64'(wd3), v3(18'h00033, 18'h00022, 18'h00011));
        tick();
        chk("ld_we_drop", 64'(RegWriteW), 64'd0);

        // Load with rvalid gaps: lanes at cycles 1, 4, 6; validM pulses ignored
        ld(4'd12, 1);
        tick();
        for (int c = 1; c <= 6; c++) begin
            rvalid = (c == 1 || c == 4 || c == 6);
            rdata  = (c == 1) ? 18'h00101 : (c == 4) ? 18'h00202 : 18'h00303;
            if (c == 2 || c == 5) alu(4'd7, 1, 18'h1, 18'h1, 18'h1);
            else validM = 0;
            tick();
            if (c < 6) begin
                chk($sformatf("gap_stall%0d", c), 64'(stallM), 64'd1);
                chk($sformatf("gap_we%0d", c), 64'(RegWriteW), 64'd0);
            end
        end
        rvalid = 0; validM = 0;
        chk("gap_stall_fall", 64'(stallM), 64'd0);
        chk("gap_we", 64'(RegWriteW), 64'd1);
        chk("gap_wa", 64'(wa3w), 64'd12);
        chk("gap_wd", 64'(wd3), v3(18'h00303, 18'h00202, 18'h00101));

        // Load with RegWrite=0 after an ALU write: no write, values hold
        alu(4'd2, 1, 18'h00001, 18'h00002, 18'h00003);
        tick();
        chk("pre_nw_wa", 64'(wa3w), 64'd2);
        ld(4'd14, 0);
        tick(); validM = 0;
        rvalid = 1;
        for (int l = 0; l < 3; l++) begin
            rdata = 18'h2AAAA;
            tick();
            chk($sformatf("nw_we%0d", l), 64'(RegWriteW), 64'd0);
        end
        rvalid = 0;
        chk("nw_stall_fall", 64'(stallM), 64'd0);
        chk("nw_wa", 64'(wa3w), 64'd2);
        chk("nw_wd", 64'(wd3), v3(18'h00001, 18'h00002, 18'h00003));

        // Reset after two lanes
        ld(4'd6, 1);
        tick(); validM = 0;
        rvalid = 1; rdata = 18'h0AAAA; tick();
        rdata = 18'h0BBBB; tick(); rvalid = 0;
        RST = 0; #1;
        chk("mid_rst_stall", 64'(stallM), 64'd0);
        chk("mid_rst_we", 64'(RegWriteW), 64'd0);
        chk("mid_rst_wa", 64'(wa3w), 64'd0);
        chk("mid_rst_wd", 64'(wd3), 64'd0);
        tick(); RST = 1;
        alu(4'd3, 1, 18'h00007, 18'h00008, 18'h00009);
        tick(); validM = 0;
        chk("post_rst_we", 64'(RegWriteW), 64'd1);
        chk("post_rst_wa", 64'(wa3w), 64'd3);
        chk("post_rst_wd", 64'(wd3), v3(18'h00007, 18'h00008, 18'h00009));
        // rvalid in IDLE is ignored
        rvalid = 1; rdata = 18'h3CCCC; tick(); rvalid = 0;
        chk("idle_rv_stall", 64'(stallM), 64'd0);
        chk("idle_rv_we", 64'(RegWriteW), 64'd0);
        chk("idle_rv_wd", 64'(wd3), v3(18'h00007, 18'h00008, 18'h00009));

        // ALU, load, ALU back-to-back with validM held
        alu(4'd1, 1, 18'h000A1, 18'h000A2, 18'h000A3);
        tick();
        chk("b2b_we1", 64'(RegWriteW), 64'd1);
        chk("b2b_wa1", 64'(wa3w), 64'd1);
        ld(4'd4, 1);
        tick();
        chk("b2b_we_ld_acc", 64'(RegWriteW), 64'd0);
        chk("b2b_stall", 64'(stallM), 64'd1);
        rvalid = 1;
        rdata = 18'h000B0; tick();
        rdata = 18'h000B1; tick();
        rdata = 18'h000B2; tick(); rvalid = 0;
        chk("b2b_we2", 64'(RegWriteW), 64'd1);
        chk("b2b_wa2", 64'(wa3w), 64'd4);
        chk("b2b_wd2", 64'(wd3), v3(18'h000B2, 18'h000B1, 18'h000B0));
        alu(4'd10, 1, 18'h000C1, 18'h000C2, 18'h000C3);
        tick(); validM = 0;
        chk("b2b_we3", 64'(RegWriteW), 64'd1);
        chk("b2b_wa3", 64'(wa3w), 64'd10);
        chk("b2b_wd3", 64'(wd3), v3(18'h000C1, 18'h000C2, 18'h000C3));
        tick();
        chk("b2b_we_drop", 64'(RegWriteW), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
